multi_port_ram_ctrl: RTL
========================

MULTI_PORT_RAM_CTRL -- requirements
Module: multi_port_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of words; legal range 1..2^ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_CH, default 4, number of requester channels; legal range 1..16.
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port start, input, NUM_CH, per-channel request pulse.
REQ-008 SHALL have port rw, input, NUM_CH, per-channel direction: 1 = write, 0 = read.
REQ-009 SHALL have port address, input, NUM_CH*ADDR_WIDTH, per-channel address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port write_data, input, NUM_CH*DATA_WIDTH, per-channel write data, packed the same way.
REQ-011 SHALL have port read_data, output, NUM_CH*DATA_WIDTH, per-channel registered read result.
REQ-012 SHALL have port done, output, NUM_CH, per-channel one-cycle completion pulse.
REQ-013 SHALL have port busy, output, NUM_CH, per-channel flag: request pending or in service.
REQ-014 SHALL have port err, output, NUM_CH, per-channel out-of-range flag, valid while done is high.

Function
REQ-015 SHALL contain an internal single-port memory of DEPTH x DATA_WIDTH, written and read only by the controller FSM.
REQ-016 SHALL capture start[i], rw[i], address[i] and write_data[i] into channel-i request registers on the edge where start[i]=1 and busy[i]=0, and set busy[i] on that edge.
REQ-017 SHALL ignore start[i] while busy[i]=1; the captured request is not modified.
REQ-018 SHALL run a 3-state FSM: IDLE, ACCESS, RESP.
REQ-019 IDLE: if any busy channel exists and none is in service, SHALL grant one channel by round-robin from pointer rr_ptr, latch the grant index, and go to ACCESS; otherwise stay in IDLE.
REQ-020 Round-robin: SHALL select the first busy channel at or after rr_ptr, wrapping from NUM_CH-1 to 0.
REQ-021 ACCESS: on the next edge, SHALL perform the granted write (mem[addr] <= data) or read (capture mem[addr]), then go to RESP.
REQ-022 RESP: SHALL drive done[g]=1 for exactly one cycle, clear busy[g], set rr_ptr to (g+1) mod NUM_CH, and return to IDLE.
REQ-023 read_data[g] SHALL update with the read value on entry to RESP and hold until the next completed read on channel g; writes SHALL NOT change read_data.
REQ-024 Address >= DEPTH: SHALL NOT write memory, SHALL load read_data[g] with 0 on a read, and SHALL assert err[g]=1 with done[g]; err is otherwise 0.
REQ-025 Latency: with the FSM in IDLE, done[i] SHALL go high 3 cycles after the cycle in which start[i] is sampled; with k requests queued ahead, add 3*k cycles.
REQ-026 Only one memory access SHALL occur per 3-cycle grant; done SHALL never be high on two channels in the same cycle.
REQ-027 start[g] asserted in the RESP cycle of channel g SHALL be ignored; it is accepted from the next cycle, when busy[g]=0.
REQ-028 A read following a completed write to the same address SHALL return the written data.

Reset
REQ-029 While rst=0, SHALL asynchronously force: FSM=IDLE, rr_ptr=0, busy=0, done=0, err=0, read_data=0, all request registers=0.
REQ-030 Reset during ACCESS or RESP SHALL abort the transaction with no done pulse; memory contents are not initialised by reset.
REQ-031 SHALL accept the first start on the first rising edge after rst deasserts.

Verification
REQ-032 Single write then read: ch0 write addr 0x10, data 0xA5 -> done[0] 3 cycles after start; ch0 read 0x10 -> read_data[0]=0xA5, err[0]=0.
REQ-033 Contention: start on all 4 channels in the same cycle after reset -> done pulses on ch0, ch1, ch2, ch3 in that order, 3 cycles apart; busy clears per channel.
REQ-034 Round-robin fairness: ch1 completes, then ch0 and ch2 request together -> ch2 is served before ch0.
REQ-035 Out of range: DEPTH=200, write 0x77 to addr 210 -> err=1 with done; read addr 210 -> read_data=0, err=1; memory unchanged.
REQ-036 Busy drop: second start on ch3 while busy[3]=1 -> ignored; exactly one done[3] pulse, first request's data used.
REQ-037 Reset mid-op: rst=0 during ACCESS -> no done pulse, busy=0, read_data=0; a new request after reset completes normally.

Source files
------------

// File: rtl/multi_port_ram_ctrl.sv
// Multi-channel front end to a single-port RAM.
// Each channel latches one request at a time. A three-state controller grants
// busy channels round-robin and performs one memory access per grant. Each
// grant produces one done pulse and, for reads, a registered result per channel.
module multi_port_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] address,
  input  logic [NUM_CH*DATA_WIDTH-1:0] write_data,
  output logic [NUM_CH*DATA_WIDTH-1:0] read_data,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth widened by one bit so DEPTH == 2^ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_reg;
  logic [CH_W-1:0]       gnt_reg;
  logic [CH_W-1:0]       rr_ptr_reg;
  logic [NUM_CH-1:0]     busy_reg;
  logic [NUM_CH-1:0]     rw_reg;
  logic [NUM_CH-1:0]     done_reg;
  logic [NUM_CH-1:0]     err_reg;
  logic [ADDR_WIDTH-1:0] addr_reg  [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_reg [NUM_CH];
  logic [DATA_WIDTH-1:0] rdata_reg [NUM_CH];
  logic [ADDR_WIDTH-1:0] addr_in   [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_in  [NUM_CH];
  logic [DATA_WIDTH-1:0] mem       [DEPTH];

  logic                  rr_found;
  logic [CH_W-1:0]       rr_sel;
  logic [CH_W-1:0]       rr_cand;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  gnt_rw;
  logic                  gnt_in_range;
  logic [IDX_W-1:0]      gnt_idx;

  // Unpack the per-channel buses and pack the per-channel read results
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign addr_in[gi]  = address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_in[gi] = write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg[gi];
  end

  assign done = done_reg;
  assign busy = busy_reg;
  assign err  = err_reg;

  // Request currently owned by the controller
  assign gnt_addr     = addr_reg[gnt_reg];
  assign gnt_wdata    = wdata_reg[gnt_reg];
  assign gnt_rw       = rw_reg[gnt_reg];
  assign gnt_in_range = ({1'b0, gnt_addr} < DEPTH_LIM);
  assign gnt_idx      = gnt_addr[IDX_W-1:0];

  // Round-robin pick: first busy channel at or after rr_ptr, wrapping.
  // Scanning downwards lets the lowest offset win.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_cand = CH_W'((int'(rr_ptr_reg) + k) % NUM_CH);
      if (busy_reg[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  // Per-channel request capture; a busy channel ignores start until released in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
      rw_reg   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_reg[i]  <= '0;
        wdata_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (start[i] && !busy_reg[i]) begin
          busy_reg[i]  <= 1'b1;
          rw_reg[i]    <= rw[i];
          addr_reg[i]  <= addr_in[i];
          wdata_reg[i] <= wdata_in[i];
        end else if (state_reg == RESP && gnt_reg == CH_W'(i)) begin
          busy_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Controller: grant in IDLE, access and raise done in ACCESS, release in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rdata_reg[i] <= '0;
      end
    end else begin
      done_reg <= '0;
      err_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (rr_found) begin
            gnt_reg   <= rr_sel;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          done_reg[gnt_reg] <= 1'b1;
          err_reg[gnt_reg]  <= !gnt_in_range;
          if (!gnt_rw) begin
            rdata_reg[gnt_reg] <= gnt_in_range ? mem[gnt_idx] : '0;
          end
          state_reg <= RESP;
        end
        RESP: begin
          rr_ptr_reg <= (gnt_reg == CH_W'(NUM_CH - 1)) ? '0 : gnt_reg + CH_W'(1);
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (state_reg == ACCESS && gnt_rw && gnt_in_range) begin
      mem[gnt_idx] <= gnt_wdata;
    end
  end

endmodule
